muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_ctrl.sv | 145 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Magnitude of a two's complement word (0x80000000 maps to itself, read as unsigned).
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? -x : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unit: shift-add multiply step or restoring divide step.
// For divide, acc holds {remainder, dividend/quotient} and mcand[31:0] the divisor.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [2*XLEN-1:0]   mcand,
    input  logic [XLEN-1:0]     mplier,
    output logic [2*XLEN-1:0]   acc_nxt,
    output logic [2*XLEN-1:0]   mcand_nxt,
    output logic [XLEN-1:0]     mplier_nxt
);

    logic [XLEN:0] trial;

    // Shifted partial remainder minus divisor; bit XLEN set means the subtract failed.
    assign trial = acc[2*XLEN-1:XLEN-1] - {1'b0, mcand[XLEN-1:0]};

    // Select multiply or divide datapath for this iteration.
    always_comb begin
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        if (is_div) begin
            if (!trial[XLEN]) begin
                acc_nxt = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = {acc[2*XLEN-2:0], 1'b0};
            end
        end else begin
            if (mplier[0]) begin
                acc_nxt = acc + mcand;
            end
            mcand_nxt  = {mcand[2*XLEN-2:0], 1'b0};
            mplier_nxt = {1'b0, mplier[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MIPS-style multiply/divide unit owning the HI/LO registers.
// Optional feature: define MULDIV_EARLY_EXIT_EN to let multiplies leave RUN
// as soon as the remaining multiplier bits are all zero.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    input  logic            hilo_rd,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [31:0]     wr_data,
    output logic            stall,
    output logic [31:0]     hi,
    output logic [31:0]     lo,
    output logic            busy,
    output logic            done
);

    state_e               state;
    logic [CNT_W-1:0]     cnt;
    logic [2*XLEN-1:0]    acc;
    logic [2*XLEN-1:0]    mcand;
    logic [XLEN-1:0]      mplier;
    logic                 is_div;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 div0;

    logic [2*XLEN-1:0]    acc_nxt;
    logic [2*XLEN-1:0]    mcand_nxt;
    logic [XLEN-1:0]      mplier_nxt;
    logic                 early_exit;

    op_e                  op_in;
    logic                 signed_op;
    logic [XLEN-1:0]      ua;
    logic [XLEN-1:0]      ub;
    logic [XLEN-1:0]      res_hi;
    logic [XLEN-1:0]      res_lo;

    muldiv_step u_step (
        .is_div     (is_div),
        .acc        (acc),
        .mcand      (mcand),
        .mplier     (mplier),
        .acc_nxt    (acc_nxt),
        .mcand_nxt  (mcand_nxt),
        .mplier_nxt (mplier_nxt)
    );

    assign op_in     = op_e'(op);
    assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign ua        = signed_op ? abs_val(a) : a;
    assign ub        = signed_op ? abs_val(b) : b;

    // Hold the pipeline only when it actually needs the unit while busy.
    assign stall = busy & (start | hilo_rd | wr_hi | wr_lo);

`ifdef MULDIV_EARLY_EXIT_EN
    assign early_exit = !is_div && (mplier_nxt == '0);
`else
    assign early_exit = 1'b0;
`endif

    // Sign correction of the unsigned magnitude result, consumed on the FIX->DONE edge.
    always_comb begin
        res_hi = acc[2*XLEN-1:XLEN];
        res_lo = acc[XLEN-1:0];
        if (is_div) begin
            res_lo = div0 ? '1 : (neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
            res_hi = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        end else if (neg_res) begin
            {res_hi, res_lo} = -acc;
        end
    end

    // FSM, iteration counter, datapath registers and architectural HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div  <= op[1];
                        acc     <= op[1] ? {{XLEN{1'b0}}, ua} : '0;
                        mcand   <= op[1] ? {{XLEN{1'b0}}, ub} : {{XLEN{1'b0}}, ua};
                        mplier  <= ub;
                        neg_res <= signed_op & (a[XLEN-1] ^ b[XLEN-1]);
                        neg_rem <= signed_op & a[XLEN-1];
                        div0    <= (b == '0);
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end else begin
                        if (wr_hi) hi <= wr_data;
                        if (wr_lo) lo <= wr_data;
                    end
                end
                S_RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand_nxt;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if ((cnt == CNT_W'(XLEN - 1)) || early_exit) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl against an arithmetic reference.
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hilo_rd;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    muldiv_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .hilo_rd (hilo_rd),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference {hi,lo} from plain arithmetic.
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'd0: return 64'(sx * sy);
            2'd1: return ux * uy;
            2'd2: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                return {32'(ux % uy), 32'(ux / uy)};
            end
        endcase
    endfunction

    // Edges from acceptance until the unit is idle again.
    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] y);
`ifdef MULDIV_EARLY_EXIT_EN
        logic [31:0] m;
        int steps;
        if (!o[1]) begin
            m = (o == 2'd0 && y[31]) ? -y : y;
            steps = 1;
            for (int i = 0; i < 32; i++) if (m[i]) steps = i + 1;
            return steps + 2;
        end
`endif
        if (o == 2'd3 && y == 32'hFFFFFFFF) return 34;
        return 34;
    endfunction

    // Issue one operation and check latency, done pulse and result.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string name);
        logic [63:0] exp;
        int n, dn, lat;
        exp = ref_res(o, x, y);
        lat = ref_lat(o, y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        n = 0; dn = 0;
        while (busy && n < 40) begin
            tick();
            n++;
            if (done) dn++;
        end
        checks++;
        if (n !== lat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, required %0d", name, n, lat);
        end
        checks++;
        if (dn !== 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d, required 1", name, dn);
        end
        checks++;
        if ({hi, lo} !== exp) begin
            errors++;
            $display("FAIL %s result: got hi=%h lo=%h, required hi=%h lo=%h", name, hi, lo, exp[63:32], exp[31:0]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 0; op = 0; a = 0; b = 0; hilo_rd = 0; wr_hi = 0; wr_lo = 0; wr_data = 0;
        tick(); tick();
        checks++;
        if ({hi, lo, busy, done, stall} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b stall=%b, required all 0", hi, lo, busy, done, stall);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_writes;
        wr_hi = 1; wr_lo = 1; wr_data = 32'hA5A5_1234;
        tick();
        wr_hi = 0; wr_lo = 0;
        checks++;
        if (hi !== 32'hA5A5_1234 || lo !== 32'hA5A5_1234) begin
            errors++;
            $display("FAIL idle_write_both: got hi=%h lo=%h, required a5a51234", hi, lo);
        end
        wr_lo = 1; wr_data = 32'h0000_BEEF;
        tick();
        wr_lo = 0;
        checks++;
        if (hi !== 32'hA5A5_1234 || lo !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL idle_write_lo: got hi=%h lo=%h, required hi=a5a51234 lo=0000beef", hi, lo);
        end
        // Start beats a same-cycle write.
        start = 1; op = 2'd1; a = 32'd2; b = 32'd3; wr_hi = 1; wr_lo = 1; wr_data = 32'hDEAD_0000;
        tick();
        start = 0; wr_hi = 0; wr_lo = 0;
        checks++;
        if (hi !== 32'hA5A5_1234 || lo !== 32'h0000_BEEF || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_beats_write: got hi=%h lo=%h busy=%b, required hi=a5a51234 lo=0000beef busy=1", hi, lo, busy);
        end
        for (int i = 0; i < 40 && busy; i++) tick();
        checks++;
        if (lo !== 32'd6 || hi !== 32'd0) begin
            errors++;
            $display("FAIL start_beats_write_result: got hi=%h lo=%h, required hi=0 lo=6", hi, lo);
        end
    endtask

    task automatic test_vectors;
        do_op(2'd0, 32'hFFFF_FFFD, 32'd7, "mult_m3x7");
        do_op(2'd3, 32'd100, 32'd7, "divu_100_7");
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        do_op(2'd2, 32'd5, 32'd0, "div_by_zero");
        do_op(2'd2, 32'hFFFF_FFFB, 32'd0, "div_neg_by_zero");
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        do_op(2'd0, 32'h8000_0000, 32'h8000_0000, "mult_min_min");
    endtask

    task automatic test_random;
        logic [1:0] o;
        logic [31:0] x, y;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = (i % 7 == 3) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(0, 15));
                2:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            do_op(o, x, y, $sformatf("random_%0d_op%0d", i, o));
        end
    endtask

    // hilo_rd and re-presented start/writes while busy: stall tracks busy, requests ignored.
    task automatic test_stall;
        int k, bad;
        logic [63:0] exp;
        exp = ref_res(2'd3, 32'd1000, 32'd33);
        start = 1; op = 2'd3; a = 32'd1000; b = 32'd33;
        tick();
        start = 0;
        tick();
        hilo_rd = 1;
        k = 1; bad = 0;
        while (k < 40) begin
            if (k >= 5 && k < 12) begin
                start = 1; op = 2'd1; a = 32'd9; b = 32'd9;
                wr_hi = 1; wr_lo = 1; wr_data = 32'h1111_2222;
            end else begin
                start = 0; wr_hi = 0; wr_lo = 0;
            end
            #1;
            if (stall !== (k < 34)) bad++;
            if (!stall) break;
            tick();
            k++;
        end
        checks++;
        if (bad != 0 || k != 34) begin
            errors++;
            $display("FAIL stall_window: got %0d bad cycles, first unstalled at %0d, required 0 and 34", bad, k);
        end
        checks++;
        if ({hi, lo} !== exp) begin
            errors++;
            $display("FAIL read_after_stall: got hi=%h lo=%h, required hi=%h lo=%h", hi, lo, exp[63:32], exp[31:0]);
        end
        hilo_rd = 0;
        tick();
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== exp) begin
            errors++;
            $display("FAIL ignored_while_busy: got busy=%b hi=%h lo=%h, required busy=0 hi=%h lo=%h", busy, hi, lo, exp[63:32], exp[31:0]);
        end
    endtask

    task automatic test_reset_mid;
        start = 1; op = 2'd0; a = 32'h1234_5678; b = 32'h0FED_CBA9;
        tick();
        start = 0;
        for (int i = 0; i < 10; i++) tick();
        #2 rst = 1;
        #1;
        checks++;
        if ({hi, lo, busy, done, stall} !== 67'd0) begin
            errors++;
            $display("FAIL reset_mid_op: got hi=%h lo=%h busy=%b done=%b, required all 0", hi, lo, busy, done);
        end
        tick();
        rst = 0;
        tick();
        do_op(2'd1, 32'd2, 32'd3, "multu_after_reset");
    endtask

    task automatic test_early;
        do_op(2'd1, 32'd5, 32'd1, "multu_5x1");
        do_op(2'd0, 32'd12345, 32'd0, "mult_by_zero");
        do_op(2'd0, 32'hFFFF_FF00, 32'hFFFF_FFF0, "mult_neg_small");
    endtask

    initial begin
        test_reset();
        test_writes();
        test_vectors();
        test_stall();
        test_reset_mid();
        test_early();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
